// File: rtl/move_sequencer.sv
// move_sequencer: top-level game sequencer for a 4x4 grid of merge nodes.
// It starts new games (clear + two spawns), launches moves into the node grid,
// waits a fixed settle time, collects merge points, spawns a new tile from an
// LFSR-chosen empty cell and flags game over when the grid is locked.
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst           synchronous, active-low reset
//   start         one-cycle pulse: begin a new game
//   dir_valid     one-cycle move request strobe
//   dir_req[3:0]  one-hot move direction
//   cell_value    16 x 4-bit cell values (cell i at [4i+3:4i]); 0 = empty
//   cell_movable  16 x 4-bit per-cell movable vectors, same bit order as dir_req
//   score_pulse   per-cell merge score strobes, bit i = cell i
//   launch_dir    direction broadcast to all nodes, pulsed for one cycle
//   preset_ext    node preset strobe
//   preset_value  preset bus, same layout as cell_value
//   busy          high whenever the sequencer is not idle
//   score         saturating merge count
//   game_over     sticky until the next start
module move_sequencer #(
    parameter int          SETTLE_CYCLES = 24,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        dir_valid,
    input  logic [3:0]  dir_req,
    input  logic [63:0] cell_value,
    input  logic [63:0] cell_movable,
    input  logic [15:0] score_pulse,
    output logic [3:0]  launch_dir,
    output logic        preset_ext,
    output logic [63:0] preset_value,
    output logic        busy,
    output logic [15:0] score,
    output logic        game_over
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        LAUNCH = 3'd2,
        SETTLE = 3'd3,
        SPAWN  = 3'd4,
        CHECK  = 3'd5
    } state_t;

    // Galois feedback mask for taps 16,14,13,11 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [4:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {12'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  dir_r;
    logic [15:0] settle_cnt_r;
    logic [1:0]  spawn_cnt_r;
    logic        spawn_wait_r;   // a preset was just issued; give the grid a cycle
    logic        settle_tail_r;  // previous cycle was SETTLE, so merges still count
    logic [15:0] score_r;
    logic        game_over_r;
    logic [15:0] lfsr_r;

    logic        dir_one_hot_s;
    logic        can_move_s;
    logic        accept_s;
    logic        any_empty_s;
    logic [3:0]  scan_idx_s;
    logic [3:0]  target_s;
    logic [3:0]  spawn_val_s;
    logic [63:0] spawn_bus_s;

    // Grid analysis: move legality, spawn target search and spawn preset image
    always_comb begin
        dir_one_hot_s = (dir_req != 4'b0000) && ((dir_req & (dir_req - 4'b0001)) == 4'b0000);
        can_move_s    = 1'b0;
        any_empty_s   = 1'b0;
        scan_idx_s    = 4'd0;
        target_s      = 4'd0;
        for (int i = 0; i < 16; i++) begin
            can_move_s = can_move_s | (|(cell_movable[4*i +: 4] & dir_req));
        end
        // 4-bit index arithmetic gives the 15 -> 0 wrap for free
        for (int k = 0; k < 16; k++) begin
            scan_idx_s = lfsr_r[3:0] + 4'(k);
            if (!any_empty_s && (cell_value[{scan_idx_s, 2'b00} +: 4] == 4'd0)) begin
                any_empty_s = 1'b1;
                target_s    = scan_idx_s;
            end else begin
                any_empty_s = any_empty_s;
            end
        end
        spawn_val_s = (lfsr_r[7:4] == 4'd0) ? 4'd2 : 4'd1;
        spawn_bus_s = cell_value;
        spawn_bus_s[{target_s, 2'b00} +: 4] = spawn_val_s;
        accept_s = dir_valid && dir_one_hot_s && !game_over_r && can_move_s;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; start has priority over a simultaneous move request
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = CLEAR;
                end else if (accept_s) begin
                    state_next_s = LAUNCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CLEAR:  state_next_s = SPAWN;
            LAUNCH: state_next_s = SETTLE;
            SETTLE: begin
                if (settle_cnt_r == SETTLE_LAST) begin
                    state_next_s = SPAWN;
                end else begin
                    state_next_s = SETTLE;
                end
            end
            SPAWN: begin
                if (!spawn_wait_r) begin
                    state_next_s = any_empty_s ? SPAWN : CHECK;
                end else if (spawn_cnt_r == 2'd1) begin
                    state_next_s = CHECK;
                end else begin
                    state_next_s = SPAWN;
                end
            end
            CHECK:   state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath: LFSR, counters, latched direction, score and game-over flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_r        <= LFSR_SEED;
            dir_r         <= 4'd0;
            settle_cnt_r  <= 16'd0;
            spawn_cnt_r   <= 2'd0;
            spawn_wait_r  <= 1'b0;
            settle_tail_r <= 1'b0;
            score_r       <= 16'd0;
            game_over_r   <= 1'b0;
        end else begin
            lfsr_r        <= {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? LFSR_TAPS : 16'h0000);
            settle_tail_r <= (state_r == SETTLE);
            if ((state_r == IDLE) && start) begin
                score_r <= 16'd0;
            end else if ((state_r == SETTLE) || settle_tail_r) begin
                score_r <= sat_add(score_r, popcount16(score_pulse));
            end else begin
                score_r <= score_r;
            end
            case (state_r)
                IDLE: begin
                    if (start) begin
                        game_over_r <= 1'b0;
                    end else if (accept_s) begin
                        dir_r <= dir_req;
                    end else begin
                        dir_r <= dir_r;
                    end
                end
                CLEAR: begin
                    spawn_cnt_r  <= 2'd2;
                    spawn_wait_r <= 1'b0;
                end
                LAUNCH: settle_cnt_r <= 16'd0;
                SETTLE: begin
                    settle_cnt_r <= settle_cnt_r + 16'd1;
                    if (settle_cnt_r == SETTLE_LAST) begin
                        spawn_cnt_r  <= 2'd1;
                        spawn_wait_r <= 1'b0;
                    end else begin
                        spawn_wait_r <= 1'b0;
                    end
                end
                SPAWN: begin
                    if (!spawn_wait_r) begin
                        if (any_empty_s) begin
                            spawn_wait_r <= 1'b1;
                        end else begin
                            spawn_cnt_r <= 2'd0;
                        end
                    end else begin
                        spawn_wait_r <= 1'b0;
                        spawn_cnt_r  <= spawn_cnt_r - 2'd1;
                    end
                end
                CHECK: begin
                    if (!any_empty_s && (cell_movable == 64'd0)) begin
                        game_over_r <= 1'b1;
                    end else begin
                        game_over_r <= game_over_r;
                    end
                end
                default: spawn_wait_r <= 1'b0;
            endcase
        end
    end

    // Output decode from registered state; launch and preset live in disjoint states
    always_comb begin
        launch_dir   = 4'b0000;
        preset_ext   = 1'b0;
        preset_value = 64'd0;
        case (state_r)
            CLEAR: preset_ext = 1'b1;
            LAUNCH: launch_dir = dir_r;
            SPAWN: begin
                if (!spawn_wait_r && any_empty_s) begin
                    preset_ext   = 1'b1;
                    preset_value = spawn_bus_s;
                end else begin
                    preset_ext = 1'b0;
                end
            end
            default: launch_dir = 4'b0000;
        endcase
        busy      = (state_r != IDLE);
        score     = score_r;
        game_over = game_over_r;
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer. The node grid is modelled as a plain
// 64-bit register updated by preset pulses; expectations come from the game rules.
module tb_move_sequencer;

    localparam int          SETTLE = 24;
    localparam logic [15:0] SEED   = 16'hACE1;
    localparam logic [63:0] ALL1   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        dir_valid = 1'b0;
    logic [3:0]  dir_req = 4'd0;
    logic [63:0] cell_value = 64'd0;
    logic [63:0] movable = 64'd0;
    logic [15:0] score_pulse = 16'd0;
    logic [3:0]  launch_dir;
    logic        preset_ext;
    logic [63:0] preset_value;
    logic        busy;
    logic [15:0] score;
    logic        game_over;

    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] m_lfsr;
    logic [15:0] m_score = 16'd0;
    logic        m_game_over = 1'b0;
    logic        load_req = 1'b0;
    logic [63:0] load_val = 64'd0;
    int          both_cnt = 0;

    typedef struct {
        logic [63:0] pre;
        logic [15:0] lf;
        logic [63:0] val;
    } rec_t;
    rec_t pulse_q[$];

    move_sequencer #(.SETTLE_CYCLES(SETTLE), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .dir_valid(dir_valid), .dir_req(dir_req),
        .cell_value(cell_value), .cell_movable(movable), .score_pulse(score_pulse),
        .launch_dir(launch_dir), .preset_ext(preset_ext), .preset_value(preset_value),
        .busy(busy), .score(score), .game_over(game_over)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic has_empty(input logic [63:0] c);
        for (int i = 0; i < 16; i++) if (c[i*4 +: 4] == 4'd0) return 1'b1;
        return 1'b0;
    endfunction

    // Expected grid after one spawn: first empty cell from lf[3:0] upward, mod 16
    function automatic logic [63:0] spawn_expect(input logic [63:0] pre, input logic [15:0] lf);
        logic [63:0] r;
        r = pre;
        for (int k = 0; k < 16; k++) begin
            int c;
            c = (int'(lf[3:0]) + k) % 16;
            if (pre[c*4 +: 4] == 4'd0) begin
                r[c*4 +: 4] = (lf[7:4] == 4'd0) ? 4'd2 : 4'd1;
                return r;
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] sat16(input logic [15:0] a, input int b);
        int t;
        t = int'(a) + b;
        return (t > 65535) ? 16'hFFFF : 16'(t);
    endfunction

    // Reference LFSR, kept in step with the DUT's reset and clock
    always @(posedge clk) begin
        if (!rst) m_lfsr <= SEED;
        else      m_lfsr <= lfsr_step(m_lfsr);
    end

    // Node grid model: preset loads the whole bus, otherwise bench loads
    always @(posedge clk) begin
        if (preset_ext) cell_value <= preset_value;
        else if (load_req) cell_value <= load_val;
    end

    // Preset pulse recorder
    always @(negedge clk) begin
        rec_t r;
        if (preset_ext === 1'b1) begin
            r.pre = cell_value;
            r.lf  = m_lfsr;
            r.val = preset_value;
            pulse_q.push_back(r);
        end
        if (preset_ext && (launch_dir != 4'd0)) both_cnt++;
    end

    task automatic load_cells(input logic [63:0] v);
        @(negedge clk); load_req = 1'b1; load_val = v;
        @(negedge clk); load_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (launch_dir !== 4'd0) $display("FAIL reset_launch: got %h want 0", launch_dir); else n_pass++;
        n_total++; if (preset_ext !== 1'b0) $display("FAIL reset_preset: got %b want 0", preset_ext); else n_pass++;
        n_total++; if (preset_value !== 64'd0) $display("FAIL reset_pvalue: got %h want 0", preset_value); else n_pass++;
        n_total++; if (score !== 16'd0) $display("FAIL reset_score: got %h want 0", score); else n_pass++;
        n_total++; if (game_over !== 1'b0) $display("FAIL reset_gameover: got %b want 0", game_over); else n_pass++;
        rst = 1'b1;
        m_score = 16'd0;
        m_game_over = 1'b0;
    endtask

    // New game: clear pulse, then two spawns; with_dir also raises dir_valid
    task automatic test_start(input logic with_dir, input string tag);
        int busy_n, launch_seen, nz;
        pulse_q.delete();
        movable = ALL1;
        @(negedge clk); start = 1'b1; dir_valid = with_dir; dir_req = 4'b0001;
        @(negedge clk); start = 1'b0; dir_valid = 1'b0;
        busy_n = 0; launch_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (launch_dir != 4'd0) launch_seen++;
            if (!busy) break;
            busy_n++;
            @(negedge clk);
        end
        m_score = 16'd0;
        m_game_over = 1'b0;
        nz = 0;
        for (int c = 0; c < 16; c++) if (cell_value[c*4 +: 4] != 4'd0) nz++;
        n_total++; if (busy_n != 6) $display("FAIL %s_busy_len: got %0d want 6", tag, busy_n); else n_pass++;
        n_total++; if (pulse_q.size() != 3) $display("FAIL %s_pulses: got %0d want 3", tag, pulse_q.size()); else n_pass++;
        if (pulse_q.size() == 3) begin
            n_total++; if (pulse_q[0].val !== 64'd0) $display("FAIL %s_clear_val: got %h want 0", tag, pulse_q[0].val); else n_pass++;
            for (int p = 1; p < 3; p++) begin
                n_total++;
                if (pulse_q[p].val !== spawn_expect(pulse_q[p].pre, pulse_q[p].lf))
                    $display("FAIL %s_spawn%0d: got %h want %h", tag, p, pulse_q[p].val, spawn_expect(pulse_q[p].pre, pulse_q[p].lf));
                else n_pass++;
            end
        end
        n_total++; if (nz != 2) $display("FAIL %s_tiles: got %0d want 2", tag, nz); else n_pass++;
        n_total++; if (score !== 16'd0) $display("FAIL %s_score: got %h want 0", tag, score); else n_pass++;
        n_total++; if (game_over !== 1'b0) $display("FAIL %s_gameover: got %b want 0", tag, game_over); else n_pass++;
        n_total++; if (launch_seen != 0) $display("FAIL %s_launch: got %0d launches want 0", tag, launch_seen); else n_pass++;
    endtask

    // One move request; mode 0 random score pulses, 1 all ones, 2 two cycles of 16'h0003
    task automatic do_move(input logic [3:0] dir, input logic [63:0] mov_before,
                           input logic [63:0] mov_after, input int mode, input string tag);
        logic        accept, empty_before;
        logic [15:0] sp;
        logic [3:0]  want_l;
        int          busy_n, launch_bad, exp_busy, exp_pulses;
        pulse_q.delete();
        movable = mov_before;
        accept = ($countones(dir) == 1) && !m_game_over && ((mov_before & {16{dir}}) != 64'd0);
        empty_before = has_empty(cell_value);
        @(negedge clk);
        dir_valid = 1'b1; dir_req = dir;
        score_pulse = (mode == 1) ? 16'hFFFF : ((mode == 0) ? 16'($urandom) : 16'd0);
        busy_n = 0; launch_bad = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            dir_valid = 1'b0;
            if (busy) busy_n++;
            want_l = (accept && i == 1) ? dir : 4'd0;
            if (launch_dir !== want_l) launch_bad++;
            if (accept && i == 2) movable = mov_after;
            case (mode)
                0: sp = 16'($urandom);
                1: sp = 16'hFFFF;
                default: sp = (i == 5 || i == 6) ? 16'h0003 : 16'h0000;
            endcase
            score_pulse = sp;
            if (accept && i >= 2 && i <= SETTLE + 2) m_score = sat16(m_score, $countones(sp));
        end
        score_pulse = 16'd0;
        exp_busy   = accept ? (1 + SETTLE + (empty_before ? 2 : 1) + 1) : 0;
        exp_pulses = (accept && empty_before) ? 1 : 0;
        if (accept) m_game_over = !has_empty(cell_value) && (mov_after == 64'd0);
        n_total++; if (launch_bad != 0) $display("FAIL %s_launch: got %0d bad cycles want 0", tag, launch_bad); else n_pass++;
        n_total++; if (busy_n != exp_busy) $display("FAIL %s_busy_len: got %0d want %0d", tag, busy_n, exp_busy); else n_pass++;
        n_total++; if (pulse_q.size() != exp_pulses) $display("FAIL %s_pulses: got %0d want %0d", tag, pulse_q.size(), exp_pulses); else n_pass++;
        if (pulse_q.size() == 1 && exp_pulses == 1) begin
            n_total++;
            if (pulse_q[0].val !== spawn_expect(pulse_q[0].pre, pulse_q[0].lf))
                $display("FAIL %s_spawn: got %h want %h", tag, pulse_q[0].val, spawn_expect(pulse_q[0].pre, pulse_q[0].lf));
            else n_pass++;
        end
        n_total++; if (score !== m_score) $display("FAIL %s_score: got %h want %h", tag, score, m_score); else n_pass++;
        n_total++; if (game_over !== m_game_over) $display("FAIL %s_gameover: got %b want %b", tag, game_over, m_game_over); else n_pass++;
    endtask

    task automatic test_illegal_dir();
        do_move(4'b0110, ALL1, ALL1, 0, "dir0110");
        do_move(4'b0000, ALL1, ALL1, 0, "dir0000");
        do_move(4'b0001, 64'hEEEE_EEEE_EEEE_EEEE & {$urandom, $urandom}, ALL1, 0, "dir_unmovable");
    endtask

    task automatic test_moves_random();
        do_move(4'b0001, 64'h0000_0000_0001_0000, ALL1, 0, "single_movable");
        for (int n = 0; n < 8; n++) begin
            logic [3:0] d;
            d = 4'b0001 << $urandom_range(0, 3);
            do_move(d, {$urandom, $urandom}, {$urandom, $urandom} | 64'h1, 0, "rand_move");
        end
    endtask

    task automatic test_score_small();
        logic [15:0] s0;
        s0 = score;
        do_move(4'b0100, ALL1, ALL1, 2, "score_0003");
        n_total++; if (score !== sat16(s0, 4)) $display("FAIL score_plus4: got %h want %h", score, sat16(s0, 4)); else n_pass++;
    endtask

    task automatic test_wrap_and_full();
        logic [63:0] v;
        for (int c = 0; c < 16; c++) v[c*4 +: 4] = 4'($urandom_range(1, 15));
        v[3:0] = 4'd0;
        load_cells(v);
        do_move(4'b0010, ALL1, ALL1, 0, "wrap");
        n_total++; if (cell_value[3:0] == 4'd0) $display("FAIL wrap_cell0: got %h want nonzero", cell_value[3:0]); else n_pass++;
        n_total++; if (cell_value[63:4] !== v[63:4]) $display("FAIL wrap_others: got %h want %h", cell_value[63:4], v[63:4]); else n_pass++;
        do_move(4'b0010, ALL1, ALL1, 0, "full_no_spawn");
        do_move(4'b1000, ALL1, 64'd0, 0, "lock_grid");
        n_total++; if (game_over !== 1'b1) $display("FAIL gameover_set: got %b want 1", game_over); else n_pass++;
        do_move(4'b1000, ALL1, ALL1, 0, "after_gameover");
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 200 && m_score != 16'hFFFF; n++) do_move(4'b0001, ALL1, ALL1, 1, "sat_fill");
        do_move(4'b0001, ALL1, ALL1, 1, "sat_hold");
        n_total++; if (score !== 16'hFFFF) $display("FAIL saturate: got %h want ffff", score); else n_pass++;
    endtask

    task automatic test_reset_mid();
        pulse_q.delete();
        movable = ALL1;
        @(negedge clk); dir_valid = 1'b1; dir_req = 4'b0100; score_pulse = 16'hFFFF;
        @(negedge clk); dir_valid = 1'b0;
        repeat (6) @(negedge clk);
        n_total++; if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", busy); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        score_pulse = 16'd0;
        m_score = 16'd0;
        m_game_over = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (launch_dir !== 4'd0) $display("FAIL midrst_launch: got %h want 0", launch_dir); else n_pass++;
        n_total++; if (preset_ext !== 1'b0) $display("FAIL midrst_preset: got %b want 0", preset_ext); else n_pass++;
        n_total++; if (score !== 16'd0) $display("FAIL midrst_score: got %h want 0", score); else n_pass++;
        n_total++; if (game_over !== 1'b0) $display("FAIL midrst_gameover: got %b want 0", game_over); else n_pass++;
        rst = 1'b1;
        repeat (30) @(negedge clk);
        n_total++; if (pulse_q.size() != 0) $display("FAIL midrst_no_pulse: got %0d want 0", pulse_q.size()); else n_pass++;
        // start on the very first cycle after reset release
        rst = 1'b0;
        @(negedge clk); rst = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_total++; if (busy !== 1'b1) $display("FAIL rst_then_start_busy: got %b want 1", busy); else n_pass++;
        n_total++; if (preset_ext !== 1'b1) $display("FAIL rst_then_start_clear: got %b want 1", preset_ext); else n_pass++;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL rst_then_start_done: got %b want 0", busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_start(1'b0, "start");
        test_illegal_dir();
        test_moves_random();
        test_score_small();
        test_wrap_and_full();
        test_start(1'b1, "start_wins");
        test_saturation();
        test_reset_mid();
        n_total++; if (both_cnt != 0) $display("FAIL exclusive_strobes: got %0d overlaps want 0", both_cnt); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/move_sequencer.md
MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 24: cycles the node grid is given to finish one shift/merge pass.
REQ-002 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value; SHALL be nonzero.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  one-cycle pulse: begin a new game.
REQ-006 dir_valid  in  1  one-cycle move request strobe.
REQ-007 dir_req  in  4  move direction, one-hot, same bit encoding as node direction/ready vectors.
REQ-008 cell_value  in  64  grid values, cell i (i=row*4+col) at [4i+3:4i]; 0 = empty.
REQ-009 cell_movable  in  64  per-cell node movable vectors, cell i at [4i+3:4i], bit order as dir_req.
REQ-010 score_pulse  in  16  per-cell node score outputs, bit i = cell i.
REQ-011 launch_dir  out  4  driven to all node ready_from inputs; starts a move.
REQ-012 preset_ext  out  1  node preset strobe.
REQ-013 preset_value  out  64  node value_from_preset bus, layout as cell_value.
REQ-014 busy  out  1  high whenever state != IDLE.
REQ-015 score  out  16  accumulated merge count.
REQ-016 game_over  out  1  sticky until next start.

Function
REQ-017 States SHALL be IDLE, CLEAR, LAUNCH, SETTLE, SPAWN, CHECK; busy = (state != IDLE).
REQ-018 IDLE + start: score<=0, game_over<=0, go CLEAR; start SHALL win over a simultaneous dir_valid.
REQ-019 IDLE + dir_valid: accepted only if dir_req is one-hot, game_over=0, and OR over all cells of (cell_movable & dir_req) is 1; dir_req latched, go LAUNCH; otherwise request dropped, stay IDLE.
REQ-020 start and dir_valid while busy SHALL be ignored (no queuing).
REQ-021 CLEAR: preset_ext=1, preset_value=0 for one cycle; then SPAWN with a spawn-remaining count of 2.
REQ-022 LAUNCH: launch_dir = latched direction for exactly one cycle, 4'b0000 at all other times; then SETTLE.
REQ-023 SETTLE: lasts exactly SETTLE_CYCLES cycles (counter); then SPAWN with spawn-remaining count 1.
REQ-024 Score: every cycle in SETTLE and the cycle after, score += popcount(score_pulse), saturating at 16'hFFFF.
REQ-025 LFSR: 16-bit Galois, taps 16,14,13,11, advances every cycle including IDLE.
REQ-026 SPAWN target: first empty cell scanning from index lfsr[3:0] upward modulo 16 (wrap 15->0).
REQ-027 SPAWN value: 4'd2 if lfsr[7:4]==0, else 4'd1.
REQ-028 SPAWN drive: preset_ext=1 for one cycle; preset_value = cell_value with target nibble replaced; all other nibbles unchanged.
REQ-029 SPAWN with no empty cell: no preset pulse, spawn count cleared, go CHECK.
REQ-030 After a preset pulse: wait one cycle for cell_value to update, then decrement spawn count; nonzero -> SPAWN again, zero -> CHECK.
REQ-031 CHECK: one cycle; game_over<=1 if no cell is 0 and all cell_movable bits are 0; go IDLE.
REQ-032 preset_ext and launch_dir SHALL never be asserted in the same cycle.

Reset
REQ-033 rst=0 at any edge, including mid-operation: state=IDLE, launch_dir=0, preset_ext=0, preset_value=0, score=0, game_over=0, busy=0, lfsr=LFSR_SEED, counters=0.
REQ-034 The first cycle after rst returns high SHALL accept start or dir_valid.

Verification
REQ-035 Reset, then start, model cells update from preset -> one all-zero preset pulse, then two pulses each adding one nonzero nibble at distinct indices; busy falls; score=0.
REQ-036 IDLE, dir_valid with dir_req=4'b0110 -> ignored, busy stays 0, no launch_dir.
REQ-037 dir_valid=1 and dir_req=4'b0001 with any cell_movable bit0=1 -> launch_dir=4'b0001 for 1 cycle, busy for 1+24+spawn+CHECK cycles, one spawn pulse; with all bit0=0 -> request dropped.
REQ-038 During SETTLE, score_pulse=16'h0003 for 2 cycles -> score increments by 4; with score preloaded at 16'hFFFE -> score ends at 16'hFFFF.
REQ-039 Only cell 0 empty, lfsr[3:0]=5 -> spawn lands at cell 0 (wrap); full grid -> no preset pulse; full grid with all movable=0 -> game_over=1, later dir_valid ignored until start.
REQ-040 rst=0 asserted during SETTLE -> next cycle all outputs at reset values; no preset pulse follows.
